// File: rtl/bnn_layer1_xnor.sv
// First BNN layer: per neuron, XNOR the pixel vector with its weight row, popcount
// CHUNK bits per cycle, and fire when the total reaches THRESH.
module bnn_layer1_xnor #(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 32,
    parameter int CHUNK  = 56,
    parameter int THRESH = 392
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [N_IN-1:0]            pixels,
    output logic [$clog2(N_OUT)-1:0]   w_addr,
    input  logic [N_IN-1:0]            w_row,
    output logic [N_OUT-1:0]           act_out,
    output logic                       act_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int NCH = N_IN / CHUNK;
    localparam int AW  = $clog2(N_IN + 1);
    localparam int NW  = $clog2(N_OUT);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(NCH - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);
    localparam logic [AW-1:0] THR    = AW'(THRESH);

    generate
        if (N_IN % CHUNK != 0) begin : g_bad_chunk
            $error("bnn_layer1_xnor: N_IN must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [NW-1:0] n;
    logic [CW-1:0] c;
    logic [AW-1:0] acc;

    logic [CHUNK-1:0] chunk_xnor;
    logic [AW-1:0]    pc;
    logic [AW-1:0]    sum;

    function automatic logic [AW-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [AW-1:0] s;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s = s + AW'(v[i]);
        end
        return s;
    endfunction

    // Bits that agree with the weight (XNOR) count as +1 matches.
    always_comb begin
        chunk_xnor = ~(pixels[c*CHUNK +: CHUNK] ^ w_row[c*CHUNK +: CHUNK]);
        pc         = popcount(chunk_xnor);
        sum        = acc + pc;
    end

    assign w_addr = n;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            n         <= '0;
            c         <= '0;
            acc       <= '0;
            act_out   <= '0;
            act_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ACCUM;
                        n         <= '0;
                        c         <= '0;
                        acc       <= '0;
                        act_out   <= '0;
                        act_valid <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (c == C_LAST) begin
                        act_out[n] <= (sum >= THR);
                        acc        <= '0;
                        c          <= '0;
                        if (n == N_LAST) begin
                            state     <= DONE;
                            act_valid <= 1'b1;
                        end else begin
                            n <= n + 1'b1;
                        end
                    end else begin
                        acc <= sum;
                        c   <= c + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
